pajaro_track: RTL and testbench

//  Parametrised walker FSM: next generation of the pajaro left/right bump walker.

---
 rtl/pajaro_track_pkg.sv | 48 ++++
 rtl/pajaro_track_sat_counter.sv | 37 +++
 rtl/pajaro_track.sv | 163 ++++++++++++++++
 tb/tb_pajaro_track.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pajaro_track_pkg.sv
// Shared definitions for the pajaro track walker: state encoding,
// output flag bit positions and small decode helpers.
package pajaro_track_pkg;

  typedef enum logic [2:0] {
    ST_WALK_L = 3'd0,
    ST_WALK_R = 3'd1,
    ST_FALL_L = 3'd2,
    ST_FALL_R = 3'd3,
    ST_DIG_L  = 3'd4,
    ST_DIG_R  = 3'd5,
    ST_SPLAT  = 3'd6
  } state_t;

  // Flag vector layout, MSB first: walk_izq, walk_der, falling, digging, splat.
  localparam int FLAG_W        = 5;
  localparam int FLAG_WALK_IZQ = 4;
  localparam int FLAG_WALK_DER = 3;
  localparam int FLAG_FALLING  = 2;
  localparam int FLAG_DIGGING  = 1;
  localparam int FLAG_SPLAT    = 0;

  // One-hot flag pattern shown while sitting in a given state.
  function automatic logic [FLAG_W-1:0] state_flags(input state_t s);
    logic [FLAG_W-1:0] f;
    f = 5'b00000;
    case (s)
      ST_WALK_L: f[FLAG_WALK_IZQ] = 1'b1;
      ST_WALK_R: f[FLAG_WALK_DER] = 1'b1;
      ST_FALL_L,
      ST_FALL_R: f[FLAG_FALLING]  = 1'b1;
      ST_DIG_L,
      ST_DIG_R:  f[FLAG_DIGGING]  = 1'b1;
      ST_SPLAT:  f[FLAG_SPLAT]    = 1'b1;
      default:   f = 5'b00000;
    endcase
    return f;
  endfunction

  function automatic logic is_walk(input state_t s);
    return (s == ST_WALK_L) || (s == ST_WALK_R);
  endfunction

  function automatic logic is_fall(input state_t s);
    return (s == ST_FALL_L) || (s == ST_FALL_R);
  endfunction

endpackage

// File: rtl/pajaro_track_sat_counter.sv
// Small up-counter that stops at MAX; synchronous clear has priority.
// Used both as a saturating fall timer and, with clr tied to at_max,
// as a wrapping step divider.
module pajaro_track_sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  // Count register: clear wins, then increment until the ceiling is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + ONE_V;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt    = r_cnt;
  assign at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/pajaro_track.sv
// Pajaro walker on an N_POS-cell track: walls turn it around, bumps turn
// it, losing ground makes it fall (long falls splat), dig mode holds it
// in place until the ground opens. All outputs come straight from flops.
module pajaro_track
  import pajaro_track_pkg::*;
#(
  parameter int N_POS      = 8,
  parameter int POS_W      = 3,
  parameter int START_POS  = 3,
  parameter int STEP_DIV   = 1,
  parameter int FALL_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             izq,
  input  logic             der,
  input  logic             ground,
  input  logic             dig,
  output logic [POS_W-1:0] pos,
  output logic             walk_izq,
  output logic             walk_der,
  output logic             falling,
  output logic             digging,
  output logic             splat
);

  localparam int FALL_W = $clog2(FALL_LIMIT + 2);
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [POS_W-1:0]  POS_ZERO  = POS_W'(0);
  localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0]  POS_START = POS_W'(START_POS);
  localparam logic [FALL_W-1:0] FALL_LIM  = FALL_W'(FALL_LIMIT);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  state_t              r_state;
  state_t              w_next;
  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    w_pos_next;
  logic [FLAG_W-1:0]   r_flags;
  logic [FLAG_W-1:0]   w_flags;

  logic [FALL_W-1:0]   w_fall_cnt;
  logic                w_fall_max;
  logic [STEP_W-1:0]   w_step_cnt;
  logic                w_step_max;
  logic                w_tick;
  logic                w_long_fall;

  // Fall timer: runs while falling, pinned at FALL_LIMIT+1, zeroed on exit.
  pajaro_track_sat_counter #(
    .WIDTH (FALL_W),
    .MAX   (FALL_LIMIT + 1)
  ) u_fall_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (is_fall(r_state) && !w_fall_max),
    .clr    (!is_fall(w_next)),
    .cnt    (w_fall_cnt),
    .at_max (w_fall_max)
  );

  // Step divider: wraps on its last value, held at zero outside walking.
  pajaro_track_sat_counter #(
    .WIDTH (STEP_W),
    .MAX   (STEP_DIV - 1)
  ) u_step_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (is_walk(r_state)),
    .clr    (w_step_max || !is_walk(w_next)),
    .cnt    (w_step_cnt),
    .at_max (w_step_max)
  );

  assign w_tick      = (w_step_cnt == STEP_LAST);
  assign w_long_fall = (w_fall_cnt > FALL_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_WALK_L;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: fall beats dig beats bump beats wall.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WALK_L: begin
        if (!ground)                         w_next = ST_FALL_L;
        else if (dig)                        w_next = ST_DIG_L;
        else if (izq || (r_pos == POS_ZERO)) w_next = ST_WALK_R;
        else                                 w_next = ST_WALK_L;
      end
      ST_WALK_R: begin
        if (!ground)                         w_next = ST_FALL_R;
        else if (dig)                        w_next = ST_DIG_R;
        else if (der || (r_pos == POS_LAST)) w_next = ST_WALK_L;
        else                                 w_next = ST_WALK_R;
      end
      ST_FALL_L: begin
        if (!ground)          w_next = ST_FALL_L;
        else if (w_long_fall) w_next = ST_SPLAT;
        else                  w_next = ST_WALK_L;
      end
      ST_FALL_R: begin
        if (!ground)          w_next = ST_FALL_R;
        else if (w_long_fall) w_next = ST_SPLAT;
        else                  w_next = ST_WALK_R;
      end
      ST_DIG_L: begin
        if (!ground) w_next = ST_FALL_L;
        else         w_next = ST_DIG_L;
      end
      ST_DIG_R: begin
        if (!ground) w_next = ST_FALL_R;
        else         w_next = ST_DIG_R;
      end
      ST_SPLAT:  w_next = ST_SPLAT;
      default:   w_next = ST_WALK_L;
    endcase
  end

  // Position step: only a non-turning walk edge on a divider tick moves.
  always_comb begin
    w_pos_next = r_pos;
    if ((r_state == ST_WALK_L) && (w_next == ST_WALK_L) && w_tick && (r_pos != POS_ZERO)) begin
      w_pos_next = r_pos - POS_ONE;
    end else if ((r_state == ST_WALK_R) && (w_next == ST_WALK_R) && w_tick && (r_pos != POS_LAST)) begin
      w_pos_next = r_pos + POS_ONE;
    end else begin
      w_pos_next = r_pos;
    end
  end

  // Output decode from the upcoming state, captured below so flags are flopped.
  always_comb begin
    w_flags = state_flags(w_next);
  end

  // Position and flag output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos   <= POS_START;
      r_flags <= state_flags(ST_WALK_L);
    end else begin
      r_pos   <= w_pos_next;
      r_flags <= w_flags;
    end
  end

  assign pos      = r_pos;
  assign walk_izq = r_flags[FLAG_WALK_IZQ];
  assign walk_der = r_flags[FLAG_WALK_DER];
  assign falling  = r_flags[FLAG_FALLING];
  assign digging  = r_flags[FLAG_DIGGING];
  assign splat    = r_flags[FLAG_SPLAT];

endmodule

// File: tb/tb_pajaro_track.sv
// Bench for pajaro_track: two instances (step divider 1 and 3) share the
// same stimulus and are compared each cycle against a behavioural model.
module tb_pajaro_track;

  localparam int NP = 8;
  localparam int SP = 3;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic izq = 1'b0;
  logic der = 1'b0;
  logic ground = 1'b1;
  logic dig = 1'b0;

  logic [2:0] pos_a, pos_b;
  logic wi_a, wd_a, fa_a, dg_a, sp_a;
  logic wi_b, wd_b, fa_b, dg_b, sp_b;

  pajaro_track #(.N_POS(8), .POS_W(3), .START_POS(3), .STEP_DIV(1), .FALL_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst), .izq(izq), .der(der), .ground(ground), .dig(dig),
    .pos(pos_a), .walk_izq(wi_a), .walk_der(wd_a), .falling(fa_a), .digging(dg_a), .splat(sp_a)
  );

  pajaro_track #(.N_POS(8), .POS_W(3), .START_POS(3), .STEP_DIV(3), .FALL_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst), .izq(izq), .der(der), .ground(ground), .dig(dig),
    .pos(pos_b), .walk_izq(wi_b), .walk_der(wd_b), .falling(fa_b), .digging(dg_b), .splat(sp_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model. mode: 0 walking, 1 falling, 2 digging, 3 splatted.
  // dir: 0 left, 1 right. ft: cycles spent falling. ph: walk cycles since last step.
  int md[2], dr[2], ps[2], ft[2], ph[2];

  function automatic int div_of(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      md[m] = 0; dr[m] = 0; ps[m] = SP; ft[m] = 0; ph[m] = 0;
    end
  endtask

  task automatic model_edge();
    bit turn;
    for (int m = 0; m < 2; m++) begin
      case (md[m])
        0: begin
          if (!ground) begin
            md[m] = 1; ft[m] = 0; ph[m] = 0;
          end else if (dig) begin
            md[m] = 2; ph[m] = 0;
          end else begin
            turn = (dr[m] == 0) ? (izq || ps[m] == 0) : (der || ps[m] == NP - 1);
            if (turn) dr[m] = 1 - dr[m];
            else if (ph[m] == div_of(m) - 1) ps[m] = ps[m] + ((dr[m] == 1) ? 1 : -1);
            ph[m] = (ph[m] + 1) % div_of(m);
          end
        end
        1: begin
          if (!ground) begin
            ft[m] = (ft[m] + 1 > FL + 1) ? FL + 1 : ft[m] + 1;
          end else begin
            md[m] = (ft[m] > FL) ? 3 : 0;
            ft[m] = 0; ph[m] = 0;
          end
        end
        2: begin
          if (!ground) begin
            md[m] = 1; ft[m] = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0] obs, exp;
    logic [2:0] p;
    for (int m = 0; m < 2; m++) begin
      obs = (m == 0) ? {wi_a, wd_a, fa_a, dg_a, sp_a} : {wi_b, wd_b, fa_b, dg_b, sp_b};
      p   = (m == 0) ? pos_a : pos_b;
      exp = {md[m] == 0 && dr[m] == 0, md[m] == 0 && dr[m] == 1, md[m] == 1, md[m] == 2, md[m] == 3};
      check_eq($sformatf("%s/div%0d/flags", tag, div_of(m)), {27'd0, obs}, {27'd0, exp});
      check_eq($sformatf("%s/div%0d/pos", tag, div_of(m)), {29'd0, p}, ps[m]);
    end
  endtask

  // Apply one input set, let one rising edge take it, then compare.
  task automatic cyc(input string tag, input logic g, input logic d, input logic l, input logic r);
    ground = g; dig = d; izq = l; der = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed between clock edges; outputs must react without an edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #7;
    check_all("reset");
    check_eq("reset/walk_izq", {31'd0, wi_a}, 32'd1);
    rst = 1'b1;

    // Walk left into the wall, turn, walk back right.
    cyc("t1", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t1/div3_hold", {29'd0, pos_b}, 32'd3);
    cyc("t1", 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("t1", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t1/pos_at_wall", {29'd0, pos_a}, 32'd0);
    check_eq("t1/div3_step", {29'd0, pos_b}, 32'd2);
    cyc("t1", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t1/turn_der", {30'd0, wd_a, pos_a == 3'd0}, 32'd3);
    for (int i = 0; i < 5; i++) cyc("t1", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t1/pos5", {29'd0, pos_a}, 32'd5);

    // Bumps: der alone in WALK_R, then both bumps in WALK_L.
    cyc("t2", 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t2/der_turn", {31'd0, wi_a}, 32'd1);
    cyc("t2", 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("t2/both_turn", {28'd0, wd_a, pos_a}, {28'd0, 1'b1, 3'd5});

    // Short fall.
    for (int i = 0; i < 3; i++) cyc("t3", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t3/land", {30'd0, wd_a, sp_a}, 32'd2);

    // Long fall, then splat absorbs everything.
    for (int i = 0; i < 6; i++) cyc("t4", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t4", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t4/splat", {27'd0, wi_a, wd_a, fa_a, dg_a, sp_a}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc("t4_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_eq("t4/splat_hold", {31'd0, sp_a}, 32'd1);
    end
    async_reset("t4_rst");

    // Dig ignores bumps, then falls to the left.
    cyc("t5", 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("t5/digging", {31'd0, dg_a}, 32'd1);
    cyc("t5", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("t5", 1'b1, 1'b1, 1'b1, 1'b1);
    cyc("t5", 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t5/falling", {31'd0, fa_a}, 32'd1);
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t5/land_izq", {31'd0, wi_a}, 32'd1);

    // Async reset mid-fall.
    cyc("t6", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("t6", 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset("t6_rst");
    check_eq("t6/rst_pos", {28'd0, wi_a, pos_a}, {28'd0, 1'b1, 3'd3});

    // Randomized run with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 1'($urandom_range(0, 99) < 78), 1'($urandom_range(0, 99) < 6),
          1'($urandom_range(0, 99) < 12), 1'($urandom_range(0, 99) < 12));
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
